// File: rtl/load_align_unit_if.sv
// Purpose : bus bundle for the load unit: load request, memory read request/response, writeback result.
// Latency : n/a (wires only).
// Backpr. : valid/ready on the load, memory-request and writeback channels; memory responses have no ready.
// Modports: slave  = the load unit itself
//           master = execute stage + data memory + writeback, as seen from outside the unit
interface load_align_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5
);
    logic              ld_valid;
    logic              ld_ready;
    logic [2:0]        ld_funct3;
    logic [ADDR_W-1:0] ld_addr;
    logic [RD_W-1:0]   ld_rd;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rsp_data;
    logic              mem_rsp_err;

    logic              wb_valid;
    logic              wb_ready;
    logic [XLEN-1:0]   wb_data;
    logic [RD_W-1:0]   wb_rd;
    logic              wb_err;

    modport slave (
        input  ld_valid, ld_funct3, ld_addr, ld_rd,
        output ld_ready,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        output wb_valid, wb_data, wb_rd, wb_err,
        input  wb_ready
    );

    modport master (
        output ld_valid, ld_funct3, ld_addr, ld_rd,
        input  ld_ready,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        input  wb_valid, wb_data, wb_rd, wb_err,
        output wb_ready
    );
endinterface

// File: rtl/load_align_unit.sv
// Purpose : sequential load unit; issues beat-aligned reads, extracts/extends byte..dword lanes, returns result + rd tag.
// Latency : accept@T, mem_req_valid@T+1, rsp@T+2, wb_valid@T+3 (single beat, no stalls); error-only loads wb_valid@T+1.
// Backpr. : one load outstanding; ld_ready only in IDLE; request held until mem_req_ready; result held until wb_ready.
// Ports   : clk, reset (sync, active-high); bus = load_align_unit_if.slave (ld_*, mem_req_*, mem_rsp_*, wb_*).
// Config  : MISALIGN_SPLIT_EN defined -> misaligned loads allowed, split into two beats when they cross a beat.
//           Undefined -> any misaligned load returns wb_err without touching memory; REQ1/WAIT1 not built.
module load_align_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    load_align_unit_if.slave bus
);
    localparam int                BYTES      = XLEN / 8;
    localparam int                OFF_W      = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] BEAT_STEP  = ADDR_W'(BYTES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
`ifdef MISALIGN_SPLIT_EN
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
`endif
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        size_q, size_d;      // log2 of access size in bytes
    logic              sgn_q, sgn_d;
    logic [OFF_W-1:0]  off_q, off_d;        // byte offset inside the first beat
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0]   beat0_q, beat0_d;
    logic              err_q, err_d;
`ifdef MISALIGN_SPLIT_EN
    logic [XLEN-1:0]   beat1_q, beat1_d;
    logic              split_q, split_d;
`endif

    // ---------------- accept-time decode ----------------
    logic [1:0]       in_size;
    logic [OFF_W-1:0] in_off;
    logic             in_illegal;
    logic             in_reject;

    assign in_size    = bus.ld_funct3[1:0];
    assign in_off     = bus.ld_addr[OFF_W-1:0];
    // 111 never exists; LD/LWU only exist on a 64-bit datapath.
    assign in_illegal = (bus.ld_funct3 == 3'b111) ||
                        ((XLEN == 32) && ((bus.ld_funct3 == 3'b011) || (bus.ld_funct3 == 3'b110)));

`ifdef MISALIGN_SPLIT_EN
    logic in_split;
    // Only a load whose bytes run past the end of the first beat needs a second read.
    assign in_split  = (32'(in_off) + (32'd1 << in_size)) > 32'(BYTES);
    assign in_reject = in_illegal;
`else
    logic [2:0] lane_mask;
    assign lane_mask = 3'b111 >> (2'd3 - in_size);
    assign in_reject = in_illegal || (|(bus.ld_addr[2:0] & lane_mask));
`endif

    // ---------------- lane extraction ----------------
    logic [2*XLEN-1:0] pair;
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   lane_keep;
    logic              sign_bit;
    logic [XLEN-1:0]   ext;

`ifdef MISALIGN_SPLIT_EN
    assign pair = {beat1_q, beat0_q};
`else
    assign pair = {{XLEN{1'b0}}, beat0_q};
`endif
    assign raw = XLEN'(pair >> {off_q, 3'b000});

    always_comb begin
        lane_keep = '1;
        sign_bit  = raw[XLEN-1];
        case (size_q)
            2'd0: begin lane_keep = XLEN'(64'h0000_0000_0000_00FF); sign_bit = raw[7];  end
            2'd1: begin lane_keep = XLEN'(64'h0000_0000_0000_FFFF); sign_bit = raw[15]; end
            2'd2: begin lane_keep = XLEN'(64'h0000_0000_FFFF_FFFF); sign_bit = raw[31]; end
            default: begin lane_keep = '1; sign_bit = raw[XLEN-1]; end
        endcase
    end

    // Full-width loads have lane_keep all ones, so the sign fill vanishes for them.
    assign ext = (raw & lane_keep) | ((sgn_q && sign_bit) ? ~lane_keep : '0);

    // ---------------- FSM ----------------
    always_comb begin
        state_d       = state_q;
        size_d        = size_q;
        sgn_d         = sgn_q;
        off_d         = off_q;
        rd_d          = rd_q;
        req_addr_d    = req_addr_q;
        beat0_d       = beat0_q;
        err_d         = err_q;
`ifdef MISALIGN_SPLIT_EN
        beat1_d       = beat1_q;
        split_d       = split_q;
`endif
        bus.ld_ready      = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.wb_valid      = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.ld_ready = 1'b1;
                if (bus.ld_valid) begin
                    size_d = in_size;
                    sgn_d  = ~bus.ld_funct3[2];
                    off_d  = in_off;
                    rd_d   = bus.ld_rd;
                    if (in_reject) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d      = 1'b0;
                        req_addr_d = bus.ld_addr & ALIGN_MASK;
`ifdef MISALIGN_SPLIT_EN
                        split_d    = in_split;
`endif
                        state_d    = S_REQ0;
                    end
                end
            end
            S_REQ0: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_d = S_WAIT0;
            end
            S_WAIT0: begin
                if (bus.mem_rsp_valid) begin
                    beat0_d = bus.mem_rsp_data;
                    err_d   = err_q | bus.mem_rsp_err;
`ifdef MISALIGN_SPLIT_EN
                    // A bus error on beat 0 does not cancel the planned second read.
                    if (split_q) begin
                        req_addr_d = req_addr_q + BEAT_STEP;
                        state_d    = S_REQ1;
                    end else begin
                        state_d = S_DONE;
                    end
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef MISALIGN_SPLIT_EN
            S_REQ1: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (bus.mem_rsp_valid) begin
                    beat1_d = bus.mem_rsp_data;
                    err_d   = err_q | bus.mem_rsp_err;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                bus.wb_valid = 1'b1;
                if (bus.wb_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            size_q     <= '0;
            sgn_q      <= 1'b0;
            off_q      <= '0;
            rd_q       <= '0;
            req_addr_q <= '0;
            beat0_q    <= '0;
            err_q      <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            beat1_q    <= '0;
            split_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            sgn_q      <= sgn_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            req_addr_q <= req_addr_d;
            beat0_q    <= beat0_d;
            err_q      <= err_d;
`ifdef MISALIGN_SPLIT_EN
            beat1_q    <= beat1_d;
            split_q    <= split_d;
`endif
        end
    end

    // ---------------- outputs ----------------
    assign bus.mem_req_addr = req_addr_q;
    assign bus.wb_rd        = rd_q;
    assign bus.wb_err       = (state_q == S_DONE) && err_q;
    assign bus.wb_data      = ((state_q == S_DONE) && !err_q) ? ext : '0;
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: one 32-bit and one 64-bit instance sharing clk/reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_load_align_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    load_align_unit_if #(.XLEN(32), .ADDR_W(32), .RD_W(5)) if32 ();
    load_align_unit_if #(.XLEN(64), .ADDR_W(32), .RD_W(5)) if64 ();

    load_align_unit #(.XLEN(32), .ADDR_W(32), .RD_W(5)) u32 (.clk(clk), .reset(reset), .bus(if32));
    load_align_unit #(.XLEN(64), .ADDR_W(32), .RD_W(5)) u64 (.clk(clk), .reset(reset), .bus(if64));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One load on the 32-bit unit; memory answers one cycle after each accepted request.
    // lat = falling edges after the accept edge until wb_valid is seen (-1 = never).
    task automatic run32(input string tag, input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] b0, input logic e0, input logic [31:0] b1, input logic e1,
                         input logic [31:0] exp_data, input logic exp_err, input int exp_nreq, input int exp_lat);
        int nreq = 0;
        int lat  = -1;
        logic pend = 1'b0;
        logic [31:0] a0;
        a0 = addr & 32'hFFFF_FFFC;
        @(negedge clk);
        chk({tag, ".ld_ready"}, 64'(if32.ld_ready), 64'd1);
        if32.ld_valid = 1'b1; if32.ld_funct3 = f3; if32.ld_addr = addr; if32.ld_rd = rd;
        @(negedge clk);
        if32.ld_valid = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if32.mem_rsp_valid = 1'b0; if32.mem_rsp_err = 1'b0; if32.mem_rsp_data = '0;
            if (if32.wb_valid) begin lat = cyc; break; end
            if (pend) begin
                if32.mem_rsp_valid = 1'b1;
                if32.mem_rsp_data  = (nreq == 1) ? b0 : b1;
                if32.mem_rsp_err   = (nreq == 1) ? e0 : e1;
                pend = 1'b0;
            end
            if (if32.mem_req_valid) begin
                chk({tag, ".req_addr"}, 64'(if32.mem_req_addr), 64'(a0 + 32'(4 * nreq)));
                nreq++;
                pend = 1'b1;
            end
            @(negedge clk);
        end
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".nreq"}, 64'(nreq), 64'(exp_nreq));
        chk({tag, ".wb_data"}, 64'(if32.wb_data), 64'(exp_data));
        chk({tag, ".wb_err"}, 64'(if32.wb_err), 64'(exp_err));
        chk({tag, ".wb_rd"}, 64'(if32.wb_rd), 64'(rd));
        if32.wb_ready = 1'b1;
        @(negedge clk);
        if32.wb_ready = 1'b0;
        chk({tag, ".wb_valid_drop"}, 64'(if32.wb_valid), 64'd0);
    endtask

    task automatic run64(input string tag, input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                         input logic [63:0] b0, input logic [63:0] b1,
                         input logic [63:0] exp_data, input logic exp_err, input int exp_nreq, input int exp_lat);
        int nreq = 0;
        int lat  = -1;
        logic pend = 1'b0;
        logic [31:0] a0;
        a0 = addr & 32'hFFFF_FFF8;
        @(negedge clk);
        chk({tag, ".ld_ready"}, 64'(if64.ld_ready), 64'd1);
        if64.ld_valid = 1'b1; if64.ld_funct3 = f3; if64.ld_addr = addr; if64.ld_rd = rd;
        @(negedge clk);
        if64.ld_valid = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if64.mem_rsp_valid = 1'b0; if64.mem_rsp_data = '0;
            if (if64.wb_valid) begin lat = cyc; break; end
            if (pend) begin
                if64.mem_rsp_valid = 1'b1;
                if64.mem_rsp_data  = (nreq == 1) ? b0 : b1;
                pend = 1'b0;
            end
            if (if64.mem_req_valid) begin
                chk({tag, ".req_addr"}, 64'(if64.mem_req_addr), 64'(a0 + 32'(8 * nreq)));
                nreq++;
                pend = 1'b1;
            end
            @(negedge clk);
        end
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".nreq"}, 64'(nreq), 64'(exp_nreq));
        chk({tag, ".wb_data"}, if64.wb_data, exp_data);
        chk({tag, ".wb_err"}, 64'(if64.wb_err), 64'(exp_err));
        chk({tag, ".wb_rd"}, 64'(if64.wb_rd), 64'(rd));
        if64.wb_ready = 1'b1;
        @(negedge clk);
        if64.wb_ready = 1'b0;
        chk({tag, ".wb_valid_drop"}, 64'(if64.wb_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        if32.ld_valid = 1'b0; if32.ld_funct3 = '0; if32.ld_addr = '0; if32.ld_rd = '0;
        if32.mem_req_ready = 1'b1; if32.mem_rsp_valid = 1'b0; if32.mem_rsp_data = '0; if32.mem_rsp_err = 1'b0;
        if32.wb_ready = 1'b0;
        if64.ld_valid = 1'b0; if64.ld_funct3 = '0; if64.ld_addr = '0; if64.ld_rd = '0;
        if64.mem_req_ready = 1'b1; if64.mem_rsp_valid = 1'b0; if64.mem_rsp_data = '0; if64.mem_rsp_err = 1'b0;
        if64.wb_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst.ld_ready", 64'(if32.ld_ready), 64'd1);
        chk("rst.req_valid", 64'(if32.mem_req_valid), 64'd0);
        chk("rst.req_addr", 64'(if32.mem_req_addr), 64'd0);
        chk("rst.wb_valid", 64'(if32.wb_valid), 64'd0);
        chk("rst.wb_data", 64'(if32.wb_data), 64'd0);
        chk("rst.wb_rd", 64'(if32.wb_rd), 64'd0);
        chk("rst.wb_err", 64'(if32.wb_err), 64'd0);
        chk("rst64.ld_ready", 64'(if64.ld_ready), 64'd1);
        chk("rst64.wb_data", if64.wb_data, 64'd0);
        reset = 1'b0;

        // 32-bit aligned loads
        run32("lb",  3'b000, 32'h0000_1003, 5'd1, 32'h80FF_0000, 1'b0, 32'h0, 1'b0, 32'hFFFF_FF80, 1'b0, 1, 2);
        run32("lbu", 3'b100, 32'h0000_1003, 5'd2, 32'h80FF_0000, 1'b0, 32'h0, 1'b0, 32'h0000_0080, 1'b0, 1, 2);
        run32("lh",  3'b001, 32'h0000_0202, 5'd3, 32'h8001_1234, 1'b0, 32'h0, 1'b0, 32'hFFFF_8001, 1'b0, 1, 2);
        run32("lhu", 3'b101, 32'h0000_0202, 5'd4, 32'h8001_1234, 1'b0, 32'h0, 1'b0, 32'h0000_8001, 1'b0, 1, 2);
        run32("lw",  3'b010, 32'h0000_0300, 5'd5, 32'hCAFE_BABE, 1'b0, 32'h0, 1'b0, 32'hCAFE_BABE, 1'b0, 1, 2);
        // Bus error, illegal funct3 encodings
        run32("lh_buserr", 3'b001, 32'h0000_0200, 5'd6, 32'h0000_1234, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1, 2);
        run32("f3_111",    3'b111, 32'h0000_0300, 5'd7, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 0, 0);
        run32("ld_on32",   3'b011, 32'h0000_0308, 5'd8, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 0, 0);
        run32("lwu_on32",  3'b110, 32'h0000_0300, 5'd9, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 0, 0);

        // Misaligned loads
`ifdef MISALIGN_SPLIT_EN
        run32("lw_split", 3'b010, 32'h0000_0102, 5'd10, 32'hDDCC_BBAA, 1'b0, 32'h1122_3344, 1'b0, 32'h3344_DDCC, 1'b0, 2, 4);
        run32("lh_mis1",  3'b001, 32'h0000_0101, 5'd11, 32'h12AB_CD34, 1'b0, 32'h0, 1'b0, 32'hFFFF_ABCD, 1'b0, 1, 2);
        run32("lw_err1",  3'b010, 32'h0000_0103, 5'd12, 32'h1111_1111, 1'b0, 32'h2222_2222, 1'b1, 32'h0, 1'b1, 2, 4);
        run32("lhu_wrap", 3'b101, 32'hFFFF_FFFF, 5'd13, 32'hAB00_0000, 1'b0, 32'h0000_00CD, 1'b0, 32'h0000_CDAB, 1'b0, 2, 4);
`else
        run32("lw_split", 3'b010, 32'h0000_0102, 5'd10, 32'hDDCC_BBAA, 1'b0, 32'h1122_3344, 1'b0, 32'h0, 1'b1, 0, 0);
        run32("lh_mis1",  3'b001, 32'h0000_0101, 5'd11, 32'h12AB_CD34, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 0, 0);
        run32("lw_err1",  3'b010, 32'h0000_0103, 5'd12, 32'h1111_1111, 1'b0, 32'h2222_2222, 1'b1, 32'h0, 1'b1, 0, 0);
        run32("lhu_wrap", 3'b101, 32'hFFFF_FFFF, 5'd13, 32'hAB00_0000, 1'b0, 32'h0000_00CD, 1'b0, 32'h0, 1'b1, 0, 0);
`endif

        // Backpressure: mem_req_ready low 3 cycles, wb_ready low 2 cycles
        @(negedge clk);
        if32.mem_req_ready = 1'b0;
        if32.ld_valid = 1'b1; if32.ld_funct3 = 3'b010; if32.ld_addr = 32'h0000_0400; if32.ld_rd = 5'd14;
        @(negedge clk);
        if32.ld_valid = 1'b0;
        chk("bp.ld_ready_busy", 64'(if32.ld_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("bp.req_valid", 64'(if32.mem_req_valid), 64'd1);
            chk("bp.req_addr", 64'(if32.mem_req_addr), 64'h400);
            if (i == 2) if32.mem_req_ready = 1'b1;
            @(negedge clk);
        end
        chk("bp.no_dup_req", 64'(if32.mem_req_valid), 64'd0);
        if32.mem_rsp_valid = 1'b1; if32.mem_rsp_data = 32'h1234_5678;
        @(negedge clk);
        if32.mem_rsp_valid = 1'b0; if32.mem_rsp_data = '0;
        for (int i = 0; i < 2; i++) begin
            chk("bp.wb_valid", 64'(if32.wb_valid), 64'd1);
            chk("bp.wb_data", 64'(if32.wb_data), 64'h1234_5678);
            chk("bp.wb_rd", 64'(if32.wb_rd), 64'd14);
            chk("bp.wb_req_idle", 64'(if32.mem_req_valid), 64'd0);
            @(negedge clk);
        end
        if32.wb_ready = 1'b1;
        @(negedge clk);
        if32.wb_ready = 1'b0;
        chk("bp.wb_done", 64'(if32.wb_valid), 64'd0);
        chk("bp.ld_ready", 64'(if32.ld_ready), 64'd1);

        // Reset in WAIT0, then a stale response
        @(negedge clk);
        if32.ld_valid = 1'b1; if32.ld_funct3 = 3'b010; if32.ld_addr = 32'h0000_0500; if32.ld_rd = 5'd15;
        @(negedge clk);
        if32.ld_valid = 1'b0;
        chk("rmid.req_valid", 64'(if32.mem_req_valid), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        if32.mem_rsp_valid = 1'b1; if32.mem_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        if32.mem_rsp_valid = 1'b0; if32.mem_rsp_data = '0;
        chk("rmid.ld_ready", 64'(if32.ld_ready), 64'd1);
        chk("rmid.wb_valid", 64'(if32.wb_valid), 64'd0);
        chk("rmid.req_valid_after", 64'(if32.mem_req_valid), 64'd0);
        @(negedge clk);
        chk("rmid.wb_valid_later", 64'(if32.wb_valid), 64'd0);
        run32("post_rst", 3'b010, 32'h0000_0504, 5'd16, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b0, 1, 2);

        // 64-bit unit
        run64("ld64",  3'b011, 32'h0000_0010, 5'd17, 64'h8877_6655_4433_2211, 64'h0, 64'h8877_6655_4433_2211, 1'b0, 1, 2);
        run64("lwu64", 3'b110, 32'h0000_0014, 5'd18, 64'h8877_6655_4433_2211, 64'h0, 64'h0000_0000_8877_6655, 1'b0, 1, 2);
        run64("lw64",  3'b010, 32'h0000_0014, 5'd19, 64'h8877_6655_4433_2211, 64'h0, 64'hFFFF_FFFF_8877_6655, 1'b0, 1, 2);
        run64("lh64",  3'b001, 32'h0000_0012, 5'd20, 64'h8877_6655_4433_2211, 64'h0, 64'h0000_0000_0000_4433, 1'b0, 1, 2);
        run64("lb64",  3'b000, 32'h0000_0017, 5'd21, 64'h8877_6655_4433_2211, 64'h0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 1, 2);
        run64("f3_111_64", 3'b111, 32'h0000_0010, 5'd22, 64'h0, 64'h0, 64'h0, 1'b1, 0, 0);
`ifdef MISALIGN_SPLIT_EN
        run64("lwu64_split", 3'b110, 32'h0000_001E, 5'd23, 64'h8877_6655_4433_2211, 64'h0000_0000_0000_BBAA,
              64'h0000_0000_BBAA_8877, 1'b0, 2, 4);
`else
        run64("lwu64_split", 3'b110, 32'h0000_001E, 5'd23, 64'h8877_6655_4433_2211, 64'h0000_0000_0000_BBAA,
              64'h0, 1'b1, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
